// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 VGA timing with registered, skew-free syncs and a frame-stable object position.
// Optional VGA_CLKDIV_EN: pixel tick is clk/2 (50 MHz clk); otherwise the tick is always high (25 MHz clk).
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pos_x_in,
  input  logic [9:0] pos_y_in,
  input  logic       pos_wr,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       pos_pending
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_XFER = 10'(V_ACTIVE - 1);

  logic       tick;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [9:0] posx_q, posx_d, posy_q, posy_d;
  logic [9:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic       pending_q, pending_d;
  logic       xfer;

`ifdef VGA_CLKDIV_EN
  logic tick_q, tick_d;

  assign tick_d = ~tick_q;
  assign tick   = tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end
`else
  assign tick = 1'b1;
`endif

  // Syncs are decoded from the next counter values so they land in the same register stage.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
    hsync_d    = !((x_d >= HS_BEG) && (x_d < HS_END));
    vsync_d    = !((y_d >= VS_BEG) && (y_d < VS_END));
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // Position hand-off happens only on the step into vertical blanking.
  always_comb begin
    posx_d     = posx_q;
    posy_d     = posy_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    pending_d  = pending_q;
    xfer       = tick && (x_q == H_LAST) && (y_q == V_XFER);
    if (xfer) begin
      if (pos_wr) begin
        posx_d = pos_x_in;
        posy_d = pos_y_in;
      end else if (pending_q) begin
        posx_d = shadow_x_q;
        posy_d = shadow_y_q;
      end
      pending_d = 1'b0;
    end else if (pos_wr) begin
      shadow_x_d = pos_x_in;
      shadow_y_d = pos_y_in;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      posx_q        <= '0;
      posy_q        <= '0;
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      pending_q     <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      pending_q     <= pending_d;
    end
  end

  assign pixelx      = x_q;
  assign pixely      = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign posx        = posx_q;
  assign posy        = posy_q;
  assign pos_pending = pending_q;

endmodule
